cache_read_select: RTL and testbench

Registered read-data selector that sits between a cache data array and the CPU load path. It takes one 128-bit cache block plus the low address bits and the load funct3, and extracts the addressed byte, halfword and word. It also produces a sign- or zero-extended 32-bit load result. Internally it is built from a 16:1 byte multiplexer, an 8:1 halfword multiplexer and a 4:1 word multiplexer, each with a DATA_WIDTH parameter.

---
 rtl/cache_read_select.sv | 167 ++++++++++++++++
 tb/tb_cache_read_select.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_read_select.sv
// Registered load-data selector: picks byte/half/word out of a 16-byte cache block
// and produces the RISC-V extended load result one cycle after a valid request.

module cache_mux16 #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [16*DATA_WIDTH-1:0] data_i,
    input  logic [3:0]               sel_i,
    output logic [DATA_WIDTH-1:0]    out_c_o
);
    localparam int unsigned N_LANES = 16;

    logic [DATA_WIDTH-1:0] lane [N_LANES];

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        assign lane[g] = data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        out_c_o = lane[sel_i];
    end
endmodule

module cache_mux8 #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic [8*DATA_WIDTH-1:0] data_i,
    input  logic [2:0]              sel_i,
    output logic [DATA_WIDTH-1:0]   out_c_o
);
    localparam int unsigned N_LANES = 8;

    logic [DATA_WIDTH-1:0] lane [N_LANES];

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        assign lane[g] = data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        out_c_o = lane[sel_i];
    end
endmodule

module cache_mux4 #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [4*DATA_WIDTH-1:0] data_i,
    input  logic [1:0]              sel_i,
    output logic [DATA_WIDTH-1:0]   out_c_o
);
    localparam int unsigned N_LANES = 4;

    logic [DATA_WIDTH-1:0] lane [N_LANES];

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        assign lane[g] = data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        out_c_o = lane[sel_i];
    end
endmodule

module cache_read_select (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [127:0] block_i,
    input  logic [3:0]   byte_i,
    input  logic [2:0]   funct3_i,
    output logic [7:0]   ByteData_o,
    output logic [15:0]  HalfData_o,
    output logic [31:0]  WordData_o,
    output logic [31:0]  data_o,
    output logic         valid_o
);
    localparam int unsigned BLOCKSIZE = 128;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned HALF_W    = 16;
    localparam int unsigned WORD_W    = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [BYTE_W-1:0] byte_c;
    logic [HALF_W-1:0] half_c;
    logic [WORD_W-1:0] word_c;
    logic [WORD_W-1:0] ext_c;

    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    cache_mux16 #(.DATA_WIDTH(BYTE_W)) u_byte_mux (
        .data_i (block_i[BLOCKSIZE-1:0]),
        .sel_i  (byte_i[3:0]),
        .out_c_o(byte_c)
    );

    // Low offset bits are dropped: accesses stay inside their natural half/word.
    cache_mux8 #(.DATA_WIDTH(HALF_W)) u_half_mux (
        .data_i (block_i[BLOCKSIZE-1:0]),
        .sel_i  (byte_i[3:1]),
        .out_c_o(half_c)
    );

    cache_mux4 #(.DATA_WIDTH(WORD_W)) u_word_mux (
        .data_i (block_i[BLOCKSIZE-1:0]),
        .sel_i  (byte_i[3:2]),
        .out_c_o(word_c)
    );

    // Load-result extension; unsupported funct3 encodings read as zero.
    always_comb begin
        ext_c = '0;
        case (funct3_i)
            F3_LB:   ext_c = {{(WORD_W-BYTE_W){byte_c[BYTE_W-1]}}, byte_c};
            F3_LH:   ext_c = {{(WORD_W-HALF_W){half_c[HALF_W-1]}}, half_c};
            F3_LW:   ext_c = word_c;
            F3_LBU:  ext_c = {{(WORD_W-BYTE_W){1'b0}}, byte_c};
            F3_LHU:  ext_c = {{(WORD_W-HALF_W){1'b0}}, half_c};
            default: ext_c = '0;
        endcase
    end

    // Data registers hold across idle cycles; valid follows the request strobe.
    always_comb begin
        byte_d  = byte_q;
        half_d  = half_q;
        word_d  = word_q;
        data_d  = data_q;
        valid_d = valid_i;
        if (valid_i) begin
            byte_d = byte_c;
            half_d = half_c;
            word_d = word_c;
            data_d = ext_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_q  <= '0;
            half_q  <= '0;
            word_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            byte_q  <= byte_d;
            half_q  <= half_d;
            word_q  <= word_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign ByteData_o = byte_q;
    assign HalfData_o = half_q;
    assign WordData_o = word_q;
    assign data_o     = data_q;
    assign valid_o    = valid_q;
endmodule

// File: tb/tb_cache_read_select.sv
// Bench for cache_read_select: directed vector table, corner sequences, and
// randomized traffic against a byte-arithmetic reference model.

module tb_cache_read_select;
    logic         clk;
    logic         rst_n;
    logic         valid_i;
    logic [127:0] block_i;
    logic [3:0]   byte_i;
    logic [2:0]   funct3_i;
    logic [7:0]   ByteData_o;
    logic [15:0]  HalfData_o;
    logic [31:0]  WordData_o;
    logic [31:0]  data_o;
    logic         valid_o;

    int checks = 0;
    int passed = 0;

    cache_read_select dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (valid_i),
        .block_i   (block_i),
        .byte_i    (byte_i),
        .funct3_i  (funct3_i),
        .ByteData_o(ByteData_o),
        .HalfData_o(HalfData_o),
        .WordData_o(WordData_o),
        .data_o    (data_o),
        .valid_o   (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] blk;
        logic [3:0]   off;
        logic [2:0]   f3;
        logic [7:0]   eb;
        logic [15:0]  eh;
        logic [31:0]  ew;
        logic [31:0]  ed;
    } vec_t;

    localparam logic [127:0] BLK_A = 128'h8F8E8D8C_8B8A8988_87868584_83828180;
    localparam logic [127:0] BLK_B = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    vec_t vecs [15];

    // Expected-state model, advanced once per clock edge
    logic [7:0]  m_b;
    logic [15:0] m_h;
    logic [31:0] m_w;
    logic [31:0] m_d;
    logic        m_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_all(input string name, input logic [7:0] eb, input logic [15:0] eh,
                           input logic [31:0] ew, input logic [31:0] ed, input logic ev);
        chk({name, ".valid"}, 32'(valid_o), 32'(ev));
        chk({name, ".byte"},  32'(ByteData_o), 32'(eb));
        chk({name, ".half"},  32'(HalfData_o), 32'(eh));
        chk({name, ".word"},  WordData_o, ew);
        chk({name, ".data"},  data_o, ed);
    endtask

    function automatic logic [7:0] ref_byte(input logic [127:0] blk, input int off);
        return 8'((blk >> (8 * off)) & 128'hFF);
    endfunction

    function automatic logic [15:0] ref_half(input logic [127:0] blk, input int off);
        int base;
        base = (off / 2) * 2;
        return {ref_byte(blk, base + 1), ref_byte(blk, base)};
    endfunction

    function automatic logic [31:0] ref_word(input logic [127:0] blk, input int off);
        int base;
        base = (off / 4) * 4;
        return {ref_byte(blk, base + 3), ref_byte(blk, base + 2),
                ref_byte(blk, base + 1), ref_byte(blk, base)};
    endfunction

    function automatic logic [31:0] ref_load(input logic [127:0] blk, input int off, input int f3);
        int b;
        int h;
        b = int'(ref_byte(blk, off));
        h = int'(ref_half(blk, off));
        case (f3)
            0: return (b >= 128) ? 32'(b - 256) : 32'(b);
            1: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            2: return ref_word(blk, off);
            4: return 32'(b);
            5: return 32'(h);
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model for the edge about to happen, using the driven inputs.
    task automatic model_step();
        if (!rst_n) begin
            m_b = '0; m_h = '0; m_w = '0; m_d = '0; m_v = 1'b0;
        end else if (valid_i) begin
            m_b = ref_byte(block_i, int'(byte_i));
            m_h = ref_half(block_i, int'(byte_i));
            m_w = ref_word(block_i, int'(byte_i));
            m_d = ref_load(block_i, int'(byte_i), int'(funct3_i));
            m_v = 1'b1;
        end else begin
            m_v = 1'b0;
        end
    endtask

    task automatic drive(input logic v, input logic [127:0] blk, input logic [3:0] off,
                         input logic [2:0] f3);
        @(negedge clk);
        valid_i  = v;
        block_i  = blk;
        byte_i   = off;
        funct3_i = f3;
    endtask

    task automatic edge_and_check(input string name);
        model_step();
        @(posedge clk);
        #1;
        chk_all(name, m_b, m_h, m_w, m_d, m_v);
    endtask

    initial begin
        vecs[0]  = '{BLK_A, 4'd5,  3'b000, 8'h85, 16'h8584, 32'h87868584, 32'hFFFFFF85};
        vecs[1]  = '{BLK_A, 4'd5,  3'b100, 8'h85, 16'h8584, 32'h87868584, 32'h00000085};
        vecs[2]  = '{BLK_A, 4'd6,  3'b001, 8'h86, 16'h8786, 32'h87868584, 32'hFFFF8786};
        vecs[3]  = '{BLK_A, 4'd7,  3'b101, 8'h87, 16'h8786, 32'h87868584, 32'h00008786};
        vecs[4]  = '{BLK_A, 4'd0,  3'b010, 8'h80, 16'h8180, 32'h83828180, 32'h83828180};
        vecs[5]  = '{BLK_A, 4'd4,  3'b010, 8'h84, 16'h8584, 32'h87868584, 32'h87868584};
        vecs[6]  = '{BLK_A, 4'd8,  3'b010, 8'h88, 16'h8988, 32'h8B8A8988, 32'h8B8A8988};
        vecs[7]  = '{BLK_A, 4'd12, 3'b010, 8'h8C, 16'h8D8C, 32'h8F8E8D8C, 32'h8F8E8D8C};
        vecs[8]  = '{BLK_A, 4'd13, 3'b010, 8'h8D, 16'h8D8C, 32'h8F8E8D8C, 32'h8F8E8D8C};
        vecs[9]  = '{BLK_B, 4'd15, 3'b000, 8'h0F, 16'h0F0E, 32'h0F0E0D0C, 32'h0000000F};
        vecs[10] = '{BLK_B, 4'd15, 3'b011, 8'h0F, 16'h0F0E, 32'h0F0E0D0C, 32'h00000000};
        vecs[11] = '{BLK_B, 4'd14, 3'b110, 8'h0E, 16'h0F0E, 32'h0F0E0D0C, 32'h00000000};
        vecs[12] = '{BLK_B, 4'd15, 3'b111, 8'h0F, 16'h0F0E, 32'h0F0E0D0C, 32'h00000000};
        vecs[13] = '{BLK_A, 4'd15, 3'b001, 8'h8F, 16'h8F8E, 32'h8F8E8D8C, 32'hFFFF8F8E};
        vecs[14] = '{BLK_A, 4'd3,  3'b101, 8'h83, 16'h8382, 32'h83828180, 32'h00008382};

        m_b = '0; m_h = '0; m_w = '0; m_d = '0; m_v = 1'b0;

        // Reset with valid asserted: everything zero
        rst_n = 1'b0; valid_i = 1'b1; block_i = BLK_A; byte_i = 4'd5; funct3_i = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 8'h0, 16'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk_all("post_reset_idle", 8'h0, 16'h0, 32'h0, 32'h0, 1'b0);

        // Directed table with constant expectations
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, vecs[i].blk, vecs[i].off, vecs[i].f3);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].eb, vecs[i].eh, vecs[i].ew, vecs[i].ed, 1'b1);
        end

        // Idle: valid drops, data holds the last table result
        drive(1'b0, '0, 4'd0, 3'b000);
        @(posedge clk);
        #1;
        chk_all("hold1", 8'h83, 16'h8382, 32'h83828180, 32'h00008382, 1'b0);
        drive(1'b0, BLK_B, 4'd9, 3'b010);
        @(posedge clk);
        #1;
        chk_all("hold2", 8'h83, 16'h8382, 32'h83828180, 32'h00008382, 1'b0);

        // Three back-to-back requests, then idle
        m_b = ByteData_o; m_h = HalfData_o; m_w = WordData_o; m_d = data_o; m_v = valid_o;
        m_b = 8'h83; m_h = 16'h8382; m_w = 32'h83828180; m_d = 32'h00008382; m_v = 1'b0;
        drive(1'b1, BLK_A, 4'd1, 3'b000);
        edge_and_check("b2b0");
        drive(1'b1, BLK_B, 4'd10, 3'b101);
        edge_and_check("b2b1");
        drive(1'b1, BLK_A, 4'd9, 3'b001);
        edge_and_check("b2b2");
        chk("b2b2.last_data", data_o, 32'hFFFF8988);
        drive(1'b0, BLK_B, 4'd0, 3'b010);
        edge_and_check("b2b_idle");

        // Reset mid-stream discards the request at that edge; next request is normal
        drive(1'b1, BLK_A, 4'd2, 3'b000);
        edge_and_check("pre_rst");
        drive(1'b1, BLK_A, 4'd11, 3'b010);
        rst_n = 1'b0;
        edge_and_check("mid_rst");
        chk("mid_rst.word_zero", WordData_o, 32'h0);
        drive(1'b1, BLK_B, 4'd11, 3'b010);
        rst_n = 1'b1;
        edge_and_check("first_after_rst");
        chk("first_after_rst.word", WordData_o, 32'h0B0A0908);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(3) != 0) ? 1'b1 : 1'b0,
                  {$urandom, $urandom, $urandom, $urandom},
                  4'($urandom_range(15)), 3'($urandom_range(7)));
            rst_n = ($urandom_range(31) != 0) ? 1'b1 : 1'b0;
            edge_and_check($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
